// File: rtl/up_down_counter.sv
// Free-running WIDTH-bit up/down counter, modulo 2**WIDTH, with an asynchronous
// active-low reset that loads RESET_VAL. Count is driven straight from a register.
module up_down_counter #(
    parameter int unsigned           WIDTH     = 4,
    parameter logic [WIDTH-1:0]      RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             UpOrDown,
    output logic [WIDTH-1:0] Count
);

    localparam logic [WIDTH-1:0] STEP_ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] next_s;

    // Next count: one step in the sampled direction; wrap-around falls out of modulo arithmetic.
    always_comb begin
        next_s = count_r;
        case (UpOrDown)
            1'b1:    next_s = count_r + STEP_ONE;
            1'b0:    next_s = count_r - STEP_ONE;
            default: next_s = RESET_VAL;
        endcase
    end

    // Counter register; reset forces RESET_VAL without waiting for a clock edge.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            count_r <= RESET_VAL;
        end else begin
            count_r <= next_s;
        end
    end

    assign Count = count_r;

endmodule

// File: tb/tb_up_down_counter.sv
// Directed bench for up_down_counter: default 4-bit instance plus WIDTH=1, WIDTH=8
// and RESET_VAL=5 variants, all sharing clock, reset and direction.
module tb_up_down_counter;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       updown   = 1'b1;
    logic [3:0] count4;
    logic [0:0] count1;
    logic [7:0] count8;
    logic [3:0] count_r5;

    int vectors     = 0;
    int miscompares = 0;

    up_down_counter #(.WIDTH(4)) dut4 (
        .Clk(clk), .reset(reset), .UpOrDown(updown), .Count(count4));
    up_down_counter #(.WIDTH(1)) dut1 (
        .Clk(clk), .reset(reset), .UpOrDown(updown), .Count(count1));
    up_down_counter #(.WIDTH(8)) dut8 (
        .Clk(clk), .reset(reset), .UpOrDown(updown), .Count(count8));
    up_down_counter #(.WIDTH(4), .RESET_VAL(4'd5)) dut_r5 (
        .Clk(clk), .reset(reset), .UpOrDown(updown), .Count(count_r5));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Put all counters in reset, then release just after an edge with the given direction.
    task automatic restart(input logic dir);
        reset = 1'b0;
        tick();
        updown = dir;
        reset  = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        vectors++;
        if (count4 !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_async: Count=%0d expected=0", count4);
        end
        for (int i = 0; i < 10; i++) begin
            updown = (i < 5) ? 1'b1 : 1'b0;
            tick();
            vectors++;
            if (count4 !== 4'd0) begin
                miscompares++;
                $display("FAIL reset_hold[%0d]: Count=%0d expected=0", i, count4);
            end
        end
    endtask

    task automatic test_count_up();
        logic [3:0] exp_v;
        updown = 1'b1;
        reset  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_v = 4'((i + 1) % 16);
            vectors++;
            if (count4 !== exp_v) begin
                miscompares++;
                $display("FAIL count_up[%0d]: Count=%0d expected=%0d", i, count4, exp_v);
            end
        end
    endtask

    task automatic test_count_down();
        logic [3:0] exp_v;
        restart(1'b0);
        for (int i = 0; i < 18; i++) begin
            tick();
            exp_v = 4'((32 - (i + 1)) % 16);
            vectors++;
            if (count4 !== exp_v) begin
                miscompares++;
                $display("FAIL count_down[%0d]: Count=%0d expected=%0d", i, count4, exp_v);
            end
        end
    endtask

    task automatic test_reversal();
        logic [3:0] exp_tab [5] = '{4'd6, 4'd5, 4'd4, 4'd5, 4'd6};
        restart(1'b1);
        for (int i = 0; i < 7; i++) tick();
        vectors++;
        if (count4 !== 4'd7) begin
            miscompares++;
            $display("FAIL reversal_start: Count=%0d expected=7", count4);
        end
        for (int i = 0; i < 5; i++) begin
            updown = (i < 3) ? 1'b0 : 1'b1;
            tick();
            vectors++;
            if (count4 !== exp_tab[i]) begin
                miscompares++;
                $display("FAIL reversal[%0d]: Count=%0d expected=%0d", i, count4, exp_tab[i]);
            end
        end
    endtask

    task automatic test_async_mid_count();
        restart(1'b1);
        for (int i = 0; i < 9; i++) tick();
        vectors++;
        if (count4 !== 4'd9) begin
            miscompares++;
            $display("FAIL mid_pre: Count=%0d expected=9", count4);
        end
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (count4 !== 4'd0) begin
            miscompares++;
            $display("FAIL mid_async: Count=%0d expected=0", count4);
        end
        tick();
        updown = 1'b1;
        reset  = 1'b1;
        tick();
        vectors++;
        if (count4 !== 4'd1) begin
            miscompares++;
            $display("FAIL mid_release: Count=%0d expected=1", count4);
        end
    endtask

    task automatic test_param_sweep();
        logic [0:0] e1;
        logic [7:0] e8;
        logic [3:0] e5;
        reset = 1'b0;
        #1;
        vectors++;
        if (count1 !== 1'b0 || count8 !== 8'd0 || count_r5 !== 4'd5) begin
            miscompares++;
            $display("FAIL sweep_reset: w1=%0d w8=%0d r5=%0d expected=0/0/5",
                     count1, count8, count_r5);
        end
        tick();
        updown = 1'b0;
        reset  = 1'b1;
        tick();
        vectors++;
        if (count1 !== 1'b1 || count8 !== 8'd255 || count_r5 !== 4'd4) begin
            miscompares++;
            $display("FAIL sweep_down_wrap: w1=%0d w8=%0d r5=%0d expected=1/255/4",
                     count1, count8, count_r5);
        end
        restart(1'b1);
        for (int i = 1; i <= 258; i++) begin
            tick();
            e1 = 1'(i % 2);
            e8 = 8'(i % 256);
            e5 = 4'((5 + i) % 16);
            vectors++;
            if (count1 !== e1 || count8 !== e8 || count_r5 !== e5) begin
                miscompares++;
                $display("FAIL sweep_up[%0d]: w1=%0d w8=%0d r5=%0d expected=%0d/%0d/%0d",
                         i, count1, count8, count_r5, e1, e8, e5);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_reversal();
        test_async_mid_count();
        test_param_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
